// File: rtl/aes_pkg.sv
// Shared AES row-rotation constants: row count, legal Nb values and per-row offsets.
package aes_pkg;
  localparam int LINHAS = 4;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael ShiftRows offsets; Nb=8 skips offset 2 for rows 2 and 3.
  function automatic int desloc_linha(input int nb, input int r);
    if (nb == 8) return (r < 2) ? r : r + 1;
    return r;
  endfunction
endpackage

// File: rtl/permuta_linhas.sv
// Combinational (Inv)ShiftRows: byte wiring generated from desloc_linha, modo picks direction.
module permuta_linhas
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              i_modo,
  input  logic [32*NB-1:0]  i_bloco,
  output logic [32*NB-1:0]  o_bloco
);
  localparam int W = 32*NB;

  for (genvar r = 0; r < LINHAS; r++) begin : g_lin
    localparam int OFF = desloc_linha(NB, r);
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int SRC_C = (c + OFF) % NB;
      localparam int SRC_D = (c - OFF + NB) % NB;
      localparam int BASE  = W - 1 - r*8*NB;
      assign o_bloco[BASE - c*8 -: 8] = i_modo ? i_bloco[BASE - SRC_D*8 -: 8]
                                               : i_bloco[BASE - SRC_C*8 -: 8];
    end
  end
endmodule

// File: rtl/rotaciona_linhas_pipe.sv
// Handshaked row-rotation stage: permute on accept, hold results in a 2-entry register FIFO.
module rotaciona_linhas_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ent_valid,
  output logic              ent_ready,
  input  logic              ent_modo,
  input  logic [32*NB-1:0]  ent_bloco,
  output logic              sai_valid,
  input  logic              sai_ready,
  output logic [32*NB-1:0]  sai_bloco,
  output logic [31:0]       contagem
);
  if (!nb_legal(NB)) begin : g_nb_ilegal
    $error("rotaciona_linhas_pipe: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] w_rot;
  logic [32*NB-1:0] r_mem [2];
  logic             r_cab;
  logic             r_cau;
  logic [1:0]       r_ocup;
  logic [31:0]      r_contagem;
  logic             w_push;
  logic             w_pop;

  permuta_linhas #(.NB(NB)) u_perm (
    .i_modo  (ent_modo),
    .i_bloco (ent_bloco),
    .o_bloco (w_rot)
  );

  // ready comes from registered occupancy only, never from sai_ready
  assign ent_ready = !rst && (r_ocup != 2'd2);
  assign sai_valid = (r_ocup != 2'd0);
  assign sai_bloco = r_mem[r_cab];
  assign contagem  = r_contagem;
  assign w_push    = ent_valid && ent_ready;
  assign w_pop     = sai_valid && sai_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_cab      <= 1'b0;
      r_cau      <= 1'b0;
      r_ocup     <= 2'd0;
      r_contagem <= 32'd0;
    end else begin
      if (w_push) begin
        r_mem[r_cau] <= w_rot;
        r_cau        <= ~r_cau;
      end
      if (w_pop) begin
        r_cab      <= ~r_cab;
        r_contagem <= r_contagem + 32'd1;
      end
      r_ocup <= r_ocup + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_rotaciona_linhas_pipe.sv
// Bench for rotaciona_linhas_pipe: vector table, handshake corner cases, random stream vs model.
module tb_rotaciona_linhas_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v4, m4, r4, er4, sv4;
  logic [127:0] b4, sb4;
  logic [31:0]  c4;
  logic         v8, m8, r8, er8, sv8;
  logic [255:0] b8, sb8;
  logic [31:0]  c8;

  rotaciona_linhas_pipe #(.NB(4)) u_dut4 (
    .clk(clk), .rst(rst), .ent_valid(v4), .ent_ready(er4), .ent_modo(m4), .ent_bloco(b4),
    .sai_valid(sv4), .sai_ready(r4), .sai_bloco(sb4), .contagem(c4));
  rotaciona_linhas_pipe #(.NB(8)) u_dut8 (
    .clk(clk), .rst(rst), .ent_valid(v8), .ent_ready(er8), .ent_modo(m8), .ent_bloco(b8),
    .sai_valid(sv8), .sai_ready(r8), .sai_bloco(sb8), .contagem(c8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: unpack to a byte matrix, rotate each row by its Rijndael offset, repack.
  function automatic logic [255:0] ref_rot(input logic [255:0] b, input bit modo, input int nb);
    logic [7:0]   st [4][8];
    int           off [4];
    logic [255:0] o;
    int           w, src;
    w = 32*nb;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        st[r][c] = b[w-1-(r*nb+c)*8 -: 8];
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = modo ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        o[w-1-(r*nb+c)*8 -: 8] = st[r][src];
      end
    return o;
  endfunction

  typedef struct {
    logic         modo;
    logic [127:0] ent;
    logic [127:0] esp;
  } vec_t;

  vec_t         tab [4];
  logic [127:0] qa, qb, orig;
  logic [255:0] pat8;
  logic [127:0] fila [$];
  int           cnt_base;

  initial begin
    tab[0] = '{1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h00112233_77445566_aabb8899_ddeeffcc};
    tab[1] = '{1'b0, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h00112233_55667744_aabb8899_ffccddee};
    tab[2] = '{1'b0, 128'h01020304_01020304_01020304_01020304, 128'h01020304_02030401_03040102_04010203};
    tab[3] = '{1'b1, 128'h01020304_01020304_01020304_01020304, 128'h01020304_04010203_03040102_02030401};

    rst = 1'b1; v4 = 0; m4 = 0; b4 = '0; r4 = 1; v8 = 0; m8 = 0; b8 = '0; r8 = 1;
    step(); step();
    chk("rst_ent_ready", {255'd0, er4}, 256'd0);
    chk("rst_sai_valid", {255'd0, sv4}, 256'd0);
    chk("rst_sai_bloco", {128'd0, sb4}, 256'd0);
    chk("rst_contagem", {224'd0, c4}, 256'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", {255'd0, er4}, 256'd1);

    // Vector table, one block at a time, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      v4 = 1; m4 = tab[i].modo; b4 = tab[i].ent;
      step();
      v4 = 0;
      chk($sformatf("vec%0d_valid", i), {255'd0, sv4}, 256'd1);
      chk($sformatf("vec%0d_bloco", i), {128'd0, sb4}, {128'd0, tab[i].esp});
      step();
    end
    chk("vec_contagem", {224'd0, c4}, 256'd4);

    // Cipher then decipher restores the block
    orig = 128'h3243f6a8_885a308d_313198a2_e0370734;
    v4 = 1; m4 = 0; b4 = orig;
    step();
    v4 = 1; m4 = 1; b4 = sb4;
    step();
    v4 = 0;
    chk("chain_roundtrip", {128'd0, sb4}, {128'd0, orig});
    step();

    // NB=8: bytes 00..1f
    for (int k = 0; k < 32; k++) pat8[255-k*8 -: 8] = k[7:0];
    v8 = 1; m8 = 0; b8 = pat8;
    step();
    v8 = 1; m8 = 1;
    chk("nb8_row3", {192'd0, sb8[63:0]}, {192'd0, 64'h1c1d1e1f18191a1b});
    chk("nb8_row2", {192'd0, sb8[127:64]}, {192'd0, 64'h1314151617101112});
    chk("nb8_cipher", sb8, ref_rot(pat8, 1'b0, 8));
    step();
    v8 = 0;
    chk("nb8_decipher", sb8, ref_rot(pat8, 1'b1, 8));
    step();

    // Back-pressure: fill both entries, hold, then drain in order
    cnt_base = int'(c4);
    qa = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    qb = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    r4 = 0; v4 = 1; m4 = 0; b4 = qa;
    step();
    chk("bp_ready_one", {255'd0, er4}, 256'd1);
    m4 = 1; b4 = qb;
    step();
    chk("bp_ready_full", {255'd0, er4}, 256'd0);
    b4 = 128'h1;
    step();
    chk("bp_head_stable", {128'd0, sb4}, ref_rot({128'd0, qa}, 1'b0, 4));
    v4 = 0; r4 = 1;
    step();
    chk("bp_second", {128'd0, sb4}, ref_rot({128'd0, qb}, 1'b1, 4));
    step();
    chk("bp_empty", {255'd0, sv4}, 256'd0);
    chk("bp_contagem", {224'd0, c4}, 256'(cnt_base + 2));

    // Full-rate random stream
    cnt_base = int'(c4);
    for (int i = 0; i < 100; i++) begin
      v4 = 1; m4 = i[0]; b4 = {$urandom, $urandom, $urandom, $urandom};
      fila.push_back(128'(ref_rot({128'd0, b4}, m4, 4)));
      step();
      chk("str_ready", {255'd0, er4}, 256'd1);
      chk("str_valid", {255'd0, sv4}, 256'd1);
      chk($sformatf("str_bloco%0d", i), {128'd0, sb4}, {128'd0, fila.pop_front()});
    end
    v4 = 0;
    step();
    chk("str_contagem", {224'd0, c4}, 256'(cnt_base + 100));
    chk("str_empty", {255'd0, sv4}, 256'd0);

    // Reset with both entries full
    r4 = 0; v4 = 1; b4 = qa;
    step(); step();
    v4 = 0;
    chk("mid_full", {255'd0, er4}, 256'd0);
    rst = 1'b1;
    step();
    chk("mid_valid", {255'd0, sv4}, 256'd0);
    chk("mid_bloco", {128'd0, sb4}, 256'd0);
    chk("mid_contagem", {224'd0, c4}, 256'd0);
    chk("mid_ready_rst", {255'd0, er4}, 256'd0);
    rst = 1'b0; r4 = 1; v4 = 1; m4 = 0; b4 = qb;
    #1;
    chk("mid_ready_after", {255'd0, er4}, 256'd1);
    step();
    v4 = 0;
    chk("mid_next_valid", {255'd0, sv4}, 256'd1);
    chk("mid_next_bloco", {128'd0, sb4}, ref_rot({128'd0, qb}, 1'b0, 4));
    step();
    chk("mid_contagem_one", {224'd0, c4}, 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
